// File: rtl/pixel_unpacker.sv
// pixel_unpacker: splits packed upstream words into single pixels and
// tags raster position and frame boundaries for the filter pixel FIFO.
module pixel_unpacker #(
   parameter int DWIDTH_WORD = 32,
   parameter int DWIDTH_PIX  = 8,
   parameter int IMG_WIDTH   = 720,
   parameter int IMG_HEIGHT  = 540,
   parameter int LSB_FIRST   = 1
) (
   input  logic                   clock,
   input  logic                   reset,
   output logic                   word_fifo_rd_en,
   input  logic [DWIDTH_WORD-1:0] word_fifo_dout,
   input  logic                   word_fifo_empty,
   output logic                   pix_fifo_wr_en,
   output logic [DWIDTH_PIX-1:0]  pix_fifo_din,
   input  logic                   pix_fifo_full,
   output logic                   frame_first,
   output logic                   frame_last
);

   localparam int PPW = DWIDTH_WORD / DWIDTH_PIX;
   localparam int LW  = (PPW > 1) ? $clog2(PPW) : 1;
   localparam int XW  = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
   localparam int YW  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

   localparam logic [LW-1:0] LANE_LAST = LW'(PPW - 1);
   localparam logic [XW-1:0] X_LAST    = XW'(IMG_WIDTH - 1);
   localparam logic [YW-1:0] Y_LAST    = YW'(IMG_HEIGHT - 1);

   typedef enum logic {
      EMPTY = 1'b0,
      HOLD  = 1'b1
   } state_t;

   state_t                 state;
   state_t                 state_nxt;
   logic [DWIDTH_WORD-1:0] hold_word;
   logic [DWIDTH_WORD-1:0] hold_word_nxt;
   logic [LW-1:0]          lane;
   logic [LW-1:0]          lane_nxt;
   logic [XW-1:0]          x;
   logic [XW-1:0]          x_nxt;
   logic [YW-1:0]          y;
   logic [YW-1:0]          y_nxt;
   logic [DWIDTH_PIX-1:0]  lanes [PPW];
   logic                   hold_valid;
   logic                   lane_last;
   logic                   x_last;
   logic                   y_last;
   logic                   wr;
   logic                   rd;

   if (DWIDTH_WORD % DWIDTH_PIX != 0) begin : g_bad_word
      $error("DWIDTH_WORD must be a multiple of DWIDTH_PIX");
   end

   if ((IMG_WIDTH * IMG_HEIGHT) % PPW != 0) begin : g_bad_frame
      $error("frame size must be a multiple of PIX_PER_WORD");
   end

   // Lane 0 is always the first pixel to emit; the packing order is
   // folded in here so the selector below is a plain index.
   for (genvar i = 0; i < PPW; i++) begin : g_lane
      localparam int SRC = (LSB_FIRST != 0) ? i : (PPW - 1 - i);
      assign lanes[i] = hold_word[SRC*DWIDTH_PIX +: DWIDTH_PIX];
   end

   // State register: held word, lane pointer and raster position.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= EMPTY;
         hold_word <= '0;
         lane      <= '0;
         x         <= '0;
         y         <= '0;
      end else begin
         state     <= state_nxt;
         hold_word <= hold_word_nxt;
         lane      <= lane_nxt;
         x         <= x_nxt;
         y         <= y_nxt;
      end
   end

   // Handshakes, lane sequencing and raster position update.
   always_comb begin
      hold_valid = (state == HOLD);
      lane_last  = (lane == LANE_LAST);
      x_last     = (x == X_LAST);
      y_last     = (y == Y_LAST);

      wr = reset & hold_valid & ~pix_fifo_full;
      rd = reset & ~word_fifo_empty
         & (~hold_valid | (wr & lane_last));

      state_nxt     = state;
      hold_word_nxt = hold_word;
      lane_nxt      = lane;
      x_nxt         = x;
      y_nxt         = y;

      unique case (state)
         EMPTY: begin
            if (rd) begin
               state_nxt     = HOLD;
               hold_word_nxt = word_fifo_dout;
               lane_nxt      = '0;
            end
         end
         HOLD: begin
            // A pop here implies the last lane is being written, so
            // the reload keeps the pixel stream free of bubbles.
            if (rd) begin
               hold_word_nxt = word_fifo_dout;
               lane_nxt      = '0;
            end else if (wr) begin
               if (lane_last) begin
                  state_nxt = EMPTY;
               end else begin
                  lane_nxt = lane + LW'(1);
               end
            end
         end
      endcase

      if (wr) begin
         if (x_last) begin
            x_nxt = '0;
            y_nxt = y_last ? '0 : y + YW'(1);
         end else begin
            x_nxt = x + XW'(1);
         end
      end

      word_fifo_rd_en = rd;
      pix_fifo_wr_en  = wr;
      pix_fifo_din    = lanes[lane];
      frame_first     = wr & (x == '0) & (y == '0);
      frame_last      = wr & x_last & y_last;
   end

endmodule

// File: tb/tb_pixel_unpacker.sv
// tb_pixel_unpacker: directed checks of pixel order, stalls, underflow,
// reset recovery and frame markers against hand-computed pixel streams.
module tb_pixel_unpacker;

   logic        clock = 1'b0;
   logic        reset;

   logic        rd_a;
   logic [31:0] dout_a;
   logic        empty_a;
   logic        wr_a;
   logic [7:0]  din_a;
   logic        full_a;
   logic        ff_a;
   logic        fl_a;

   logic        rd_b;
   logic [31:0] dout_b;
   logic        empty_b;
   logic        wr_b;
   logic [7:0]  din_b;
   logic        full_b;
   logic        ff_b;
   logic        fl_b;

   always #5 clock = ~clock;

   pixel_unpacker #(
      .DWIDTH_WORD(32),
      .DWIDTH_PIX (8),
      .IMG_WIDTH  (4),
      .IMG_HEIGHT (2),
      .LSB_FIRST  (1)
   ) dut_a (
      .clock          (clock),
      .reset          (reset),
      .word_fifo_rd_en(rd_a),
      .word_fifo_dout (dout_a),
      .word_fifo_empty(empty_a),
      .pix_fifo_wr_en (wr_a),
      .pix_fifo_din   (din_a),
      .pix_fifo_full  (full_a),
      .frame_first    (ff_a),
      .frame_last     (fl_a)
   );

   pixel_unpacker #(
      .DWIDTH_WORD(32),
      .DWIDTH_PIX (8),
      .IMG_WIDTH  (4),
      .IMG_HEIGHT (1),
      .LSB_FIRST  (0)
   ) dut_b (
      .clock          (clock),
      .reset          (reset),
      .word_fifo_rd_en(rd_b),
      .word_fifo_dout (dout_b),
      .word_fifo_empty(empty_b),
      .pix_fifo_wr_en (wr_b),
      .pix_fifo_din   (din_b),
      .pix_fifo_full  (full_b),
      .frame_first    (ff_b),
      .frame_last     (fl_b)
   );

   logic [31:0] q_a [$];
   logic [31:0] q_b [$];
   bit          pend_a;
   bit          pend_b;
   bit          rst_c;
   bit          full_c;
   bit          mt_c;
   int          cyc;
   int          c_rel;

   int la_d [$];
   int la_ff [$];
   int la_fl [$];
   int la_cyc [$];
   int ra_cyc [$];
   int lb_d [$];
   int lb_ff [$];
   int lb_fl [$];
   int lb_cyc [$];
   int rd_mt;

   int errs   = 0;
   int checks = 0;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
      end
   endtask

   function automatic int at(input int q[$], input int i);
      if (i < q.size()) return q[i];
      return -1;
   endfunction

   // One clock: apply the model pops and controls just after the rising
   // edge, then sample the DUT outputs on the falling edge.
   task automatic step();
      @(posedge clock);
      #1;
      cyc++;
      if (pend_a && q_a.size() > 0) void'(q_a.pop_front());
      if (pend_b && q_b.size() > 0) void'(q_b.pop_front());
      reset   = rst_c;
      full_a  = full_c;
      full_b  = 1'b0;
      empty_a = mt_c || (q_a.size() == 0);
      dout_a  = (q_a.size() > 0) ? q_a[0] : 32'h0;
      empty_b = (q_b.size() == 0);
      dout_b  = (q_b.size() > 0) ? q_b[0] : 32'h0;
      @(negedge clock);
      if (wr_a) begin
         la_d.push_back(int'(din_a));
         la_ff.push_back(int'(ff_a));
         la_fl.push_back(int'(fl_a));
         la_cyc.push_back(cyc);
      end
      if (wr_b) begin
         lb_d.push_back(int'(din_b));
         lb_ff.push_back(int'(ff_b));
         lb_fl.push_back(int'(fl_b));
         lb_cyc.push_back(cyc);
      end
      if (rd_a) ra_cyc.push_back(cyc);
      if (rd_a && mt_c) rd_mt++;
      pend_a = rd_a;
      pend_b = rd_b;
   endtask

   task automatic clear_logs();
      la_d.delete();
      la_ff.delete();
      la_fl.delete();
      la_cyc.delete();
      ra_cyc.delete();
      lb_d.delete();
      lb_ff.delete();
      lb_fl.delete();
      lb_cyc.delete();
      rd_mt = 0;
   endtask

   task automatic start();
      rst_c  = 1'b0;
      full_c = 1'b0;
      mt_c   = 1'b0;
      repeat (2) step();
      chk("rst_wr", int'(wr_a), 0);
      chk("rst_rd", int'(rd_a), 0);
      chk("rst_din", int'(din_a), 0);
      clear_logs();
   endtask

   task automatic check_a(input string tag, input int n,
                          input int base, input int c0,
                          input int per);
      chk({tag, "_count"}, la_d.size(), n);
      for (int i = 0; i < n; i++) begin
         chk({tag, "_pix"}, at(la_d, i), (base + i) & 8'hff);
         chk({tag, "_ff"}, at(la_ff, i), int'(i % per == 0));
         chk({tag, "_fl"}, at(la_fl, i), int'(i % per == per - 1));
         if (c0 >= 0) chk({tag, "_cyc"}, at(la_cyc, i), c0 + i);
      end
   endtask

   task automatic load_a(input int base, input int nw);
      for (int k = 0; k < nw; k++) begin
         q_a.push_back({8'(base + 4*k + 3), 8'(base + 4*k + 2),
                        8'(base + 4*k + 1), 8'(base + 4*k)});
      end
   endtask

   initial begin
      reset   = 1'b0;
      full_a  = 1'b0;
      full_b  = 1'b0;
      empty_a = 1'b1;
      empty_b = 1'b1;
      dout_a  = '0;
      dout_b  = '0;
      pend_a  = 1'b0;
      pend_b  = 1'b0;
      cyc     = 0;
      rd_mt   = 0;

      // Basic stream, plus MSB-first lane order on the second DUT.
      start();
      chk("rst_ff", int'(ff_a), 0);
      chk("rst_fl", int'(fl_a), 0);
      chk("rst_rd_b", int'(rd_b), 0);
      chk("rst_wr_b", int'(wr_b), 0);
      load_a(0, 2);
      q_b.push_back(32'h00010203);
      rst_c = 1'b1;
      c_rel = cyc + 1;
      repeat (12) step();
      check_a("basic", 8, 0, c_rel + 1, 8);
      chk("basic_rd_n", ra_cyc.size(), 2);
      chk("basic_rd0", at(ra_cyc, 0), c_rel);
      chk("basic_rd1", at(ra_cyc, 1), at(la_cyc, 3));
      chk("basic_q", q_a.size(), 0);
      chk("msb_count", lb_d.size(), 4);
      for (int i = 0; i < 4; i++) begin
         chk("msb_pix", at(lb_d, i), i);
         chk("msb_ff", at(lb_ff, i), int'(i == 0));
         chk("msb_fl", at(lb_fl, i), int'(i == 3));
         chk("msb_cyc", at(lb_cyc, i), c_rel + 1 + i);
      end

      // Downstream full for 3 cycles while pixel 02 is presented.
      start();
      load_a(0, 2);
      rst_c = 1'b1;
      c_rel = cyc + 1;
      for (int r = 0; r < 16; r++) begin
         full_c = (r >= 3 && r <= 5);
         step();
         if (r >= 3 && r <= 5) begin
            chk("full_wr", int'(wr_a), 0);
            chk("full_din", int'(din_a), 2);
         end
      end
      full_c = 1'b0;
      check_a("full", 8, 0, -1, 8);
      chk("full_c1", at(la_cyc, 1), c_rel + 2);
      chk("full_c2", at(la_cyc, 2), c_rel + 6);
      chk("full_c3", at(la_cyc, 3), c_rel + 7);
      chk("full_rd_n", ra_cyc.size(), 2);
      chk("full_rd1", at(ra_cyc, 1), at(la_cyc, 3));

      // Upstream empty for 5 cycles across the first word boundary.
      start();
      load_a(0, 2);
      rst_c = 1'b1;
      c_rel = cyc + 1;
      for (int r = 0; r < 16; r++) begin
         mt_c = (r >= 4 && r <= 8);
         step();
      end
      mt_c = 1'b0;
      check_a("mt", 8, 0, -1, 8);
      chk("mt_c3", at(la_cyc, 3), c_rel + 4);
      chk("mt_c4", at(la_cyc, 4), c_rel + 10);
      chk("mt_spur_rd", rd_mt, 0);
      chk("mt_rd_n", ra_cyc.size(), 2);
      chk("mt_rd1", at(ra_cyc, 1), c_rel + 9);

      // Reset after pixel 05, then a fresh frame from (0,0).
      start();
      load_a(0, 2);
      rst_c = 1'b1;
      repeat (7) step();
      chk("mid_count", la_d.size(), 6);
      rst_c = 1'b0;
      step();
      chk("mid_rst_wr", int'(wr_a), 0);
      chk("mid_rst_rd", int'(rd_a), 0);
      chk("mid_rst_din", int'(din_a), 0);
      chk("mid_rst_ff", int'(ff_a), 0);
      chk("mid_rst_fl", int'(fl_a), 0);
      step();
      chk("mid_q", q_a.size(), 0);
      clear_logs();
      load_a(8'h10, 2);
      rst_c = 1'b1;
      c_rel = cyc + 1;
      repeat (12) step();
      check_a("rec", 8, 8'h10, c_rel + 1, 8);

      // Three back-to-back frames.
      start();
      load_a(0, 6);
      rst_c = 1'b1;
      c_rel = cyc + 1;
      repeat (30) step();
      check_a("b2b", 24, 0, c_rel + 1, 8);
      chk("b2b_rd_n", ra_cyc.size(), 6);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
